bias_acc_bank: RTL

Multi-channel, batch-aware bias-gradient accumulator for the backprop datapath. It sums BATCH signed samples per channel for CH channels in parallel, then presents one scaled, saturated update per channel on a valid/ready output. The upstream error/delta stage sits on its input, and the bias-update/weight-memory write stage sits on its output. It replaces the single-lane free-running accumulator, adding reset, batch counting, back-pressure, clear, scaling and saturation.

---
 rtl/dnnbp_pkg.sv | 32 +++
 rtl/bias_acc_lane.sv | 75 +++++++
 rtl/bias_acc_bank.sv | 98 +++++++++
 3 files changed

// File: rtl/dnnbp_pkg.sv
// Shared types and helpers for the backprop bias-gradient datapath.
// Saturation bounds are returned at a fixed wide width so any lane can compare against them.
package dnnbp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int SAT_W = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_max(input int w);
    logic signed [SAT_W-1:0] one;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_min(input int w);
    logic signed [SAT_W-1:0] one;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    return -(one <<< (w - 1));
  endfunction

endpackage

// File: rtl/bias_acc_lane.sv
// One channel: batch accumulator, arithmetic scaling shift and clamp to the output width.
// The output register captures the sum including the sample being accepted on the last beat.
module bias_acc_lane
  import dnnbp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BATCH = 8,
  parameter int SHIFT = 0,
  localparam int ACC_W = WIDTH + clog2(BATCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_zero,
  input  logic             i_add,
  input  logic             i_load,
  input  logic             i_clr_out,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sat
);

  localparam logic signed [SAT_W-1:0] MAX_W = sat_max(WIDTH);
  localparam logic signed [SAT_W-1:0] MIN_W = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] MAX_V = MAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_V = MIN_W[WIDTH-1:0];

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shift;
  logic signed [SAT_W-1:0] w_wide;
  logic [WIDTH-1:0]        w_res;
  logic                    w_sat;
  logic [WIDTH-1:0]        r_out;
  logic                    r_sat;

  assign w_sum   = r_acc + ACC_W'($signed(i_data));
  assign w_shift = w_sum >>> SHIFT;
  assign w_wide  = SAT_W'(w_shift);

  always_comb begin
    w_sat = 1'b0;
    w_res = w_shift[WIDTH-1:0];
    if (w_wide > MAX_W) begin
      w_sat = 1'b1;
      w_res = MAX_V;
    end else if (w_wide < MIN_W) begin
      w_sat = 1'b1;
      w_res = MIN_V;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_out <= '0;
      r_sat <= 1'b0;
    end else begin
      if (i_zero)
        r_acc <= '0;
      else if (i_add)
        r_acc <= w_sum;
      if (i_clr_out) begin
        r_out <= '0;
        r_sat <= 1'b0;
      end else if (i_load) begin
        r_out <= w_res;
        r_sat <= w_sat;
      end
    end
  end

  assign o_data = r_out;
  assign o_sat  = r_sat;

endmodule

// File: rtl/bias_acc_bank.sv
// CH-lane batch accumulator emitting one scaled, saturated bias update per BATCH samples.
// state | meaning
// IDLE  | after reset, nothing accepted or offered
// ACC   | accepting samples into the lane accumulators
// HOLD  | update presented, waiting for the consumer
module bias_acc_bank
  import dnnbp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CH    = 4,
  parameter int BATCH = 8,
  parameter int SHIFT = 0,
  localparam int CNT_W = clog2(BATCH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*WIDTH-1:0] out_data,
  output logic [CH-1:0]       sat,
  output logic [CNT_W-1:0]    count
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             w_clr;
  logic             w_accept;
  logic             w_last;
  logic             w_emit;

  // clr is ignored in IDLE and overrides accept/emit everywhere else
  assign w_clr    = clr & (r_state != IDLE);
  assign w_accept = in_valid & (r_state == ACC) & ~clr;
  assign w_last   = w_accept & (r_count == CNT_W'(BATCH - 1));
  assign w_emit   = out_ready & (r_state == HOLD) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = ACC;
      ACC:     if (!w_clr && w_last) w_next = HOLD;
      HOLD:    if (w_clr || w_emit) w_next = ACC;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ACC:     in_ready = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (w_clr || w_emit)
      r_count <= '0;
    else if (w_accept)
      r_count <= r_count + 1'b1;
  end

  assign count = r_count;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    bias_acc_lane #(
      .WIDTH(WIDTH),
      .BATCH(BATCH),
      .SHIFT(SHIFT)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_zero   (w_clr | w_emit),
      .i_add    (w_accept),
      .i_load   (w_last),
      .i_clr_out(w_clr),
      .i_data   (in_data[c*WIDTH +: WIDTH]),
      .o_data   (out_data[c*WIDTH +: WIDTH]),
      .o_sat    (sat[c])
    );
  end

endmodule
